wb_copy_master: RTL

//  Wishbone initiator that copies a block of 32-bit words from one slave address range to another.

---
 rtl/wb_copy_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wb_copy_master.sv
// Wishbone block-copy initiator: moves len_i 32-bit words from src to dst using
// single read/write cycles with cyc released between transfers.
module wb_copy_master #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, READ, RGAP, WRITE, WGAP, FINISH, FAULT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [31:0]      buf_q, buf_d, adr_q, adr_d;
    logic [LEN_W-1:0] len_q, len_d, words_q, words_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             we_q, we_d, cyc_q, cyc_d;
    logic [3:0]       sel_q, sel_d;
    logic             last_word, to_expire, fault;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        buf_d     = buf_q;
        adr_d     = adr_q;
        len_d     = len_q;
        words_d   = words_q;
        to_d      = to_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        fault     = 1'b0;
        last_word = (words_q + LEN_W'(1)) == len_q;
        to_expire = (to_q + TO_W'(1)) == TO_LIMIT;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d   = {src_addr_i[31:2], 2'b00};
                        dst_d   = {dst_addr_i[31:2], 2'b00};
                        adr_d   = {src_addr_i[31:2], 2'b00};
                        len_d   = len_i;
                        words_d = '0;
                        to_d    = '0;
                        busy_d  = 1'b1;
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = READ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            READ: begin
                // err wins over a simultaneous ack
                if (wb_err_i) begin
                    fault = 1'b1;
                end else if (wb_ack_i) begin
                    buf_d   = wb_dat_i;
                    cyc_d   = 1'b0;
                    state_d = RGAP;
                end else if (to_expire) begin
                    fault = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            RGAP: begin
                adr_d   = dst_q;
                we_d    = 1'b1;
                cyc_d   = 1'b1;
                to_d    = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (wb_err_i) begin
                    fault = 1'b1;
                end else if (wb_ack_i) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    words_d = words_q + LEN_W'(1);
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    if (last_word) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = WGAP;
                    end
                end else if (to_expire) begin
                    fault = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            WGAP: begin
                adr_d   = src_q;
                we_d    = 1'b0;
                cyc_d   = 1'b1;
                to_d    = '0;
                state_d = READ;
            end
            FINISH:  state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fault) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FAULT;
        end

        sel_d = cyc_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            adr_q   <= '0;
            len_q   <= '0;
            words_q <= '0;
            to_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            sel_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            adr_q   <= adr_d;
            len_q   <= len_d;
            words_q <= words_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            sel_q   <= sel_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign words_done_o = words_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = buf_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;

endmodule
